// File: rtl/hangman_pkg.sv
// Shared letter codes, FSM state encoding and default sizing for the hangman progress datapath.
package hangman_pkg;

    localparam int unsigned DEFAULT_WORD_LEN       = 5;
    localparam int unsigned DEFAULT_LETTER_W       = 5;
    localparam int unsigned DEFAULT_MAX_LIVES      = 6;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 500_000_000;

    localparam int unsigned NUM_LETTERS = 26;

    localparam logic [4:0] LETTER_A     = 5'd0;
    localparam logic [4:0] LETTER_Z     = 5'd25;
    localparam logic [4:0] LETTER_DUMMY = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WON,
        S_LOST
    } state_t;

    // One-hot used-letter bit for a code; codes past Z map to no bit at all.
    function automatic logic [NUM_LETTERS-1:0] letter_bit(input logic [4:0] code);
        logic [NUM_LETTERS-1:0] one;
        one = NUM_LETTERS'(1);
        return (code > LETTER_Z) ? '0 : (one << (code - LETTER_A));
    endfunction

endpackage

// File: rtl/hangman_progress_if.sv
// Guess/status bundle between control_letter (master) and hangman_progress (slave).
interface hangman_progress_if
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEFAULT_WORD_LEN,
    parameter int unsigned LETTER_W = DEFAULT_LETTER_W
);

    logic                new_game;
    logic [WORD_LEN-1:0] active_mask;
    logic                guess_valid;
    logic [LETTER_W-1:0] guess;
    logic [WORD_LEN-1:0] hit_mask;

    logic                busy;
    logic [WORD_LEN-1:0] revealed;
    logic [2:0]          lives_left;
    logic                result_valid;
    logic                result_hit;
    logic                result_repeat;
    logic                result_bad;
    logic                won;
    logic                lost;

    modport master (
        output new_game, active_mask, guess_valid, guess, hit_mask,
        input  busy, revealed, lives_left, result_valid, result_hit,
               result_repeat, result_bad, won, lost
    );

    modport slave (
        input  new_game, active_mask, guess_valid, guess, hit_mask,
        output busy, revealed, lives_left, result_valid, result_hit,
               result_repeat, result_bad, won, lost
    );

endinterface

// File: rtl/hangman_guess_timer.sv
// Per-guess idle counter: pulses expire_o on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
module hangman_guess_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    assign expire_o = enable_i && (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i || !enable_i || expire_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/hangman_progress.sv
// Hangman round tracker: revealed mask, lives, used letters, win/lose FSM.
// Optional per-guess idle penalty enabled by defining HANGMAN_GUESS_TIMEOUT_EN.
module hangman_progress
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN       = DEFAULT_WORD_LEN,
    parameter int unsigned LETTER_W       = DEFAULT_LETTER_W,
    parameter int unsigned MAX_LIVES      = DEFAULT_MAX_LIVES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    hangman_progress_if.slave bus
);

    if (MAX_LIVES < 1 || MAX_LIVES > 7 || LETTER_W != 5 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("hangman_progress: MAX_LIVES must be 1..7, LETTER_W 5, TIMEOUT_CYCLES >= 1");
    end

    localparam logic [2:0] FULL_LIVES = 3'(MAX_LIVES);

    state_t                 state_q;
    logic [WORD_LEN-1:0]    revealed_q;
    logic [WORD_LEN-1:0]    active_q;
    logic [2:0]             lives_q;
    logic [NUM_LETTERS-1:0] used_q;
    logic                   busy_q;
    logic                   result_valid_q;
    logic                   result_hit_q;
    logic                   result_repeat_q;
    logic                   result_bad_q;
    logic                   won_q;
    logic                   lost_q;

    logic [NUM_LETTERS-1:0] letter;
    logic [WORD_LEN-1:0]    hits;
    logic [WORD_LEN-1:0]    revealed_d;
    logic [2:0]             lives_d;
    logic                   bad;
    logic                   rpt;
    logic                   new_hit;
    logic                   timer_expire;

    always_comb begin
        letter     = letter_bit(5'(bus.guess));
        bad        = (5'(bus.guess) > LETTER_Z);
        rpt        = |(used_q & letter);
        hits       = bus.hit_mask & active_q;
        revealed_d = revealed_q | hits;
        new_hit    = |(hits & ~revealed_q);
        lives_d    = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
    end

`ifdef HANGMAN_GUESS_TIMEOUT_EN
    hangman_guess_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i ((state_q != S_PLAY) || bus.new_game || bus.guess_valid),
        .enable_i(state_q == S_PLAY),
        .expire_o(timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    // Result flags and busy are only ever set on the edge into S_CHECK, so they last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            revealed_q      <= '0;
            active_q        <= '0;
            lives_q         <= FULL_LIVES;
            used_q          <= '0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_repeat_q <= 1'b0;
            result_bad_q    <= 1'b0;
            won_q           <= 1'b0;
            lost_q          <= 1'b0;
        end else begin
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_repeat_q <= 1'b0;
            result_bad_q    <= 1'b0;
            if (bus.new_game) begin
                state_q    <= S_PLAY;
                revealed_q <= '0;
                active_q   <= bus.active_mask;
                lives_q    <= FULL_LIVES;
                used_q     <= '0;
                won_q      <= 1'b0;
                lost_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_PLAY: begin
                        if (bus.guess_valid) begin
                            state_q         <= S_CHECK;
                            busy_q          <= 1'b1;
                            result_valid_q  <= 1'b1;
                            result_bad_q    <= bad;
                            result_repeat_q <= !bad && rpt;
                            if (!bad && !rpt) begin
                                used_q       <= used_q | letter;
                                revealed_q   <= revealed_d;
                                result_hit_q <= new_hit;
                                if (hits == '0) lives_q <= lives_d;
                            end
                        end else if (timer_expire) begin
                            state_q        <= S_CHECK;
                            busy_q         <= 1'b1;
                            result_valid_q <= 1'b1;
                            lives_q        <= lives_d;
                        end
                    end
                    S_CHECK: begin
                        if ((revealed_q & active_q) == active_q) begin
                            state_q <= S_WON;
                            won_q   <= 1'b1;
                        end else if (lives_q == 3'd0) begin
                            state_q <= S_LOST;
                            lost_q  <= 1'b1;
                        end else begin
                            state_q <= S_PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.revealed      = revealed_q;
    assign bus.lives_left    = lives_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.result_hit    = result_hit_q;
    assign bus.result_repeat = result_repeat_q;
    assign bus.result_bad    = result_bad_q;
    assign bus.won           = won_q;
    assign bus.lost          = lost_q;

endmodule

// File: tb/tb_hangman_progress.sv
// Scoreboarded bench for hangman_progress: directed rounds with hand-computed results.
module tb_hangman_progress;
    import hangman_pkg::*;

    localparam int unsigned WL = 5;
    localparam int unsigned LW = 5;

    // Letter codes used by the directed rounds.
    localparam logic [4:0] L_A = 5'd0,  L_B = 5'd1,  L_C = 5'd2,  L_E = 5'd4,  L_I = 5'd8;
    localparam logic [4:0] L_Q = 5'd16, L_R = 5'd17, L_S = 5'd18, L_T = 5'd19, L_U = 5'd20;
    localparam logic [4:0] L_W = 5'd22, L_Y = 5'd24, L_Z = 5'd25;

    typedef struct packed {
        logic       busy;
        logic       hit;
        logic       rep;
        logic       bad;
        logic [4:0] rev;
        logic [2:0] lives;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   results_seen = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    hangman_progress_if #(.WORD_LEN(WL), .LETTER_W(LW)) bus ();

    hangman_progress #(
        .WORD_LEN      (WL),
        .LETTER_W      (LW),
        .MAX_LIVES     (6),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic void chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (!reset && bus.result_valid) begin
            a = '{busy: bus.busy, hit: bus.result_hit, rep: bus.result_repeat, bad: bus.result_bad,
                  rev: bus.revealed, lives: bus.lives_left};
            results_seen++;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=0x%0h required=none", a);
            end else begin
                e = expq.pop_front();
                chk($sformatf("result#%0d{busy,hit,rep,bad,rev,lives}", results_seen), a, e);
            end
        end
    end

    task automatic send_guess(input logic [4:0] g, input logic [4:0] hm,
                              input logic eh, input logic er, input logic eb,
                              input logic [4:0] erev, input logic [2:0] el);
        expq.push_back('{busy: 1'b1, hit: eh, rep: er, bad: eb, rev: erev, lives: el});
        @(negedge clk);
        bus.guess_valid = 1'b1;
        bus.guess       = g;
        bus.hit_mask    = hm;
        @(negedge clk);
        bus.guess_valid = 1'b0;
        bus.hit_mask    = '0;
        @(negedge clk);
    endtask

    task automatic send_ignored(input logic [4:0] g, input logic [4:0] hm);
        @(negedge clk);
        bus.guess_valid = 1'b1;
        bus.guess       = g;
        bus.hit_mask    = hm;
        @(negedge clk);
        bus.guess_valid = 1'b0;
        bus.hit_mask    = '0;
        @(negedge clk);
    endtask

    task automatic start_game(input logic [4:0] mask);
        @(negedge clk);
        bus.new_game    = 1'b1;
        bus.active_mask = mask;
        @(negedge clk);
        bus.new_game    = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [4:0] rev, input logic [2:0] lives,
                                input logic w, input logic l);
        chk({tag, ".revealed"}, bus.revealed, rev);
        chk({tag, ".lives"}, bus.lives_left, lives);
        chk({tag, ".won_lost"}, {bus.won, bus.lost}, {w, l});
        chk({tag, ".busy_valid"}, {bus.busy, bus.result_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.new_game    = 1'b0;
        bus.active_mask = '0;
        bus.guess_valid = 1'b0;
        bus.guess       = '0;
        bus.hit_mask    = '0;
        repeat (2) @(negedge clk);
        check_status("reset", 5'b00000, 3'd6, 1'b0, 1'b0);
        chk("reset.flags", {bus.result_hit, bus.result_repeat, bus.result_bad}, 3'b000);
        reset = 1'b0;

        // Idle: guesses before any new_game are ignored.
        send_ignored(L_S, 5'b00001);
        check_status("idle", 5'b00000, 3'd6, 1'b0, 1'b0);

        // Round 1: "STAY" (S=bit0, T=bit1, A=bit2, Y=bit3).
        start_game(5'b01111);
        check_status("start1", 5'b00000, 3'd6, 1'b0, 1'b0);
        send_guess(L_S, 5'b00001, 1'b1, 1'b0, 1'b0, 5'b00001, 3'd6);
        send_guess(L_S, 5'b00001, 1'b0, 1'b1, 1'b0, 5'b00001, 3'd6);
        send_guess(LETTER_DUMMY, 5'b00000, 1'b0, 1'b0, 1'b1, 5'b00001, 3'd6);
        // T, with a second guess held through the busy cycle that must be dropped.
        expq.push_back('{busy: 1'b1, hit: 1'b1, rep: 1'b0, bad: 1'b0, rev: 5'b00011, lives: 3'd6});
        @(negedge clk);
        bus.guess_valid = 1'b1;
        bus.guess       = L_T;
        bus.hit_mask    = 5'b00010;
        @(negedge clk);
        chk("busy_in_check", bus.busy, 1'b1);
        bus.guess       = L_Q;
        bus.hit_mask    = 5'b00000;
        @(negedge clk);
        bus.guess_valid = 1'b0;
        @(negedge clk);
        send_guess(L_A, 5'b00100, 1'b1, 1'b0, 1'b0, 5'b00111, 3'd6);
        send_guess(L_E, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00111, 3'd5);
        send_guess(L_Y, 5'b01000, 1'b1, 1'b0, 1'b0, 5'b01111, 3'd5);
        check_status("won1", 5'b01111, 3'd5, 1'b1, 1'b0);
        send_ignored(L_Z, 5'b00000);
        check_status("won1_hold", 5'b01111, 3'd5, 1'b1, 1'b0);

        // Round 2: six misses to lose.
        start_game(5'b01111);
        check_status("start2", 5'b00000, 3'd6, 1'b0, 1'b0);
        send_guess(L_Q, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd5);
        send_guess(L_W, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd4);
        send_guess(L_E, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd3);
        send_guess(L_R, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd2);
        send_guess(L_U, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd1);
        send_guess(L_I, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0);
        check_status("lost2", 5'b00000, 3'd0, 1'b0, 1'b1);
        send_ignored(L_S, 5'b00001);
        check_status("lost2_hold", 5'b00000, 3'd0, 1'b0, 1'b1);

        // Round 3: new_game together with a guess; the guess is dropped.
        @(negedge clk);
        bus.new_game    = 1'b1;
        bus.active_mask = 5'b01111;
        bus.guess_valid = 1'b1;
        bus.guess       = L_S;
        bus.hit_mask    = 5'b00001;
        @(negedge clk);
        bus.new_game    = 1'b0;
        bus.guess_valid = 1'b0;
        bus.hit_mask    = '0;
        @(negedge clk);
        check_status("newgame_vs_guess", 5'b00000, 3'd6, 1'b0, 1'b0);
        send_guess(L_S, 5'b00001, 1'b1, 1'b0, 1'b0, 5'b00001, 3'd6);
        // Hit only on an inactive position counts as a miss.
        send_guess(L_B, 5'b10000, 1'b0, 1'b0, 1'b0, 5'b00001, 3'd5);

        // Reset asserted while in S_CHECK: outputs clear before the next edge.
        @(negedge clk);
        bus.guess_valid = 1'b1;
        bus.guess       = L_T;
        bus.hit_mask    = 5'b00010;
        @(posedge clk);
        #1;
        chk("pre_reset.busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check_status("mid_check_reset", 5'b00000, 3'd6, 1'b0, 1'b0);
        @(negedge clk);
        bus.guess_valid = 1'b0;
        bus.hit_mask    = '0;
        reset           = 1'b0;
        send_ignored(L_T, 5'b00010);
        check_status("after_reset_idle", 5'b00000, 3'd6, 1'b0, 1'b0);

        // Degenerate empty word: first valid guess wins.
        start_game(5'b00000);
        send_guess(L_C, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd5);
        check_status("empty_word", 5'b00000, 3'd5, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hangman_progress.md
Name: hangman_progress

Overview:
- Game-progress datapath sitting directly downstream of the letter-comparison control (control_letter).
- Consumes each evaluated guess together with its per-position hit mask, which is the l1..l5 enables packed into a vector.
- Keeps the revealed-position mask, remaining lives, and the set of already-used letters.
- Decides win/lose and supplies the HEX/LEDR display logic with stable status.

Parameters:
- WORD_LEN, 5, number of letter positions (matches l1..l5).
- LETTER_W, 5, letter code width (A=0 .. Z=25; 5'b11111 = dummy/unused position).
- MAX_LIVES, 6, wrong guesses allowed before loss (1..7).
- TIMEOUT_CYCLES, 500_000_000, idle cycles per guess before penalty. Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  one-cycle pulse; clears progress and starts a round.
- active_mask  in  WORD_LEN  positions holding real letters; sampled on new_game.
- guess_valid  in  1  one-cycle pulse; guess and hit_mask are valid this cycle.
- guess  in  LETTER_W  guessed letter code.
- hit_mask  in  WORD_LEN  positions matching the guess (from control_letter enables).
- busy  out  1  high in S_CHECK; guess_valid is ignored while high.
- revealed  out  WORD_LEN  positions guessed correctly so far.
- lives_left  out  3  remaining lives.
- result_valid  out  1  one-cycle pulse qualifying the three flags below.
- result_hit  out  1  last guess revealed at least one new position.
- result_repeat  out  1  last guess letter was already used.
- result_bad  out  1  last guess code > 25 (dummy/invalid).
- won  out  1  round won; held until new_game or reset.
- lost  out  1  round lost; held until new_game or reset.

Behaviour:
- Reset (async, high): state S_IDLE; revealed=0; lives_left=MAX_LIVES; used-letter vector (26 bits) = 0; all outputs 0 except lives_left.
- States: S_IDLE, S_PLAY, S_CHECK, S_WON, S_LOST.
- new_game in any state:
  - revealed=0, lives_left=MAX_LIVES, used=0.
  - Latch active_mask; go to S_PLAY next cycle.
  - new_game has priority over a simultaneous guess_valid, which is dropped.
- S_IDLE, S_WON, S_LOST: guess_valid ignored; no state change.
- S_PLAY, guess_valid=1, at that clock edge:
  - bad (guess>25): no change to revealed, lives, or used.
  - repeat (used[guess]=1): no change.
  - otherwise:
    - Set used[guess].
    - revealed |= hit_mask & active_mask.
    - If (hit_mask & active_mask)==0, decrement lives_left (saturate at 0).
  - Next state S_CHECK.
- S_CHECK, exactly one cycle:
  - busy=1, result_valid=1, flags reflect the guess taken in S_PLAY.
  - result_hit=1 only if a new bit was added to revealed.
  - Next state, first match wins:
    - S_WON if (revealed & active_mask)==active_mask.
    - S_LOST if lives_left==0.
    - Otherwise S_PLAY.
- Latency: guess_valid at cycle N → result_valid at N+1 → won/lost/next guess accepted at N+2.
- won=1 only in S_WON; lost=1 only in S_LOST; the two are mutually exclusive.
- active_mask==0 at new_game → S_WON after the first valid non-repeat guess. Degenerate; not an error.
- Reset mid-round returns to S_IDLE immediately; no partial update is retained.

Optional Feature:
- Macro HANGMAN_GUESS_TIMEOUT_EN.
- Defined:
  - A counter runs in S_PLAY and clears on entry to S_PLAY and on guess_valid.
  - When it reaches TIMEOUT_CYCLES-1, lives_left decrements (saturating) and the FSM enters S_CHECK with result_valid=1 and all flags 0.
  - A guess_valid in the same cycle as expiry wins; the timer is discarded.
- Undefined: no counter; TIMEOUT_CYCLES unused; lives change only on guesses.

Decomposition:
- hangman_pkg holds:
  - Letter constants: LETTER_A=5'd0, LETTER_Z=5'd25, LETTER_DUMMY=5'b11111.
  - NUM_LETTERS=26.
  - State encoding for S_IDLE..S_LOST.
  - Default WORD_LEN.
- One sub-module, hangman_guess_timer (load/clear/expire counter), instantiated only under HANGMAN_GUESS_TIMEOUT_EN.

Test Plan:
- Word "STAY", active_mask=5'b01111, MAX_LIVES=6:
  - Guess S hit 0001 → revealed=0001, result_hit=1, lives=6.
  - Then T, A, Y hits → won=1 two cycles after the last guess.
- Six misses (Q,W,E,R,U,I, hit_mask=0) → lives 5..0, lost=1 after the sixth; a further guess_valid gives no change.
- Guess S twice → second gives result_repeat=1, lives unchanged, revealed unchanged.
- Invalid and busy inputs:
  - guess=5'b11111 → result_bad=1, no state change.
  - guess_valid asserted during S_CHECK (busy=1) → ignored.
- Simultaneous events:
  - new_game and guess_valid in the same cycle → guess dropped, lives=MAX_LIVES.
  - reset asserted mid-S_CHECK → outputs at reset values before the next edge.
- With HANGMAN_GUESS_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - No guess for 8 cycles → lives 6→5, result_valid with all flags 0.
  - Guess at cycle 7 → timer restarts, no penalty.
